mem_port_arbiter: RTL and testbench

- Shares the single 16-bit memory port among three requesters: A = instruction fetch, B = load/store, C = serial/debug loader.
- Drives the 2-bit select of the 3-way 16-bit operand mux that steers address and write data onto the port, plus memory enable and write strobe.
- Sequences each access over a fixed memory latency and returns read data with a one-cycle acknowledge to the winning requester.

---
 rtl/mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 16-bit memory port among three requesters
// (A = instruction fetch, B = load/store, C = serial/debug loader).
// A winner is granted the port for MEM_LAT cycles, then receives a one-cycle
// ack together with registered read data.  The requester that was just
// acknowledged is masked from arbitration in its ack cycle.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin priority starting
// after the last winner; when undefined, priority is fixed A > B > C.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              req_c,
    input  logic              we_a,
    input  logic              we_b,
    input  logic              we_c,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              gnt_c,
    output logic              ack_a,
    output logic              ack_b,
    output logic              ack_c,
    output logic [1:0]        sel,
    output logic              mem_en,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic [1:0] IDX_A = 2'd0;
    localparam logic [1:0] IDX_B = 2'd1;
    localparam logic [1:0] IDX_C = 2'd2;

    // Counter is loaded with MEM_LAT-1 so ACCESS lasts exactly MEM_LAT cycles.
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    // Requester index to one-hot grant/ack vector (bit 0 = A).
    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            IDX_A:   oh = 3'b001;
            IDX_B:   oh = 3'b010;
            IDX_C:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Round-robin pick: search starts at the requester after last.
    // Returns {valid, index}.
    function automatic logic [2:0] pick_rr(input logic [2:0] elig, input logic [1:0] last);
        logic [1:0] first;
        logic [1:0] second;
        logic [1:0] third;
        logic [2:0] res;
        case (last)
            IDX_A: begin
                first  = IDX_B;
                second = IDX_C;
                third  = IDX_A;
            end
            IDX_B: begin
                first  = IDX_C;
                second = IDX_A;
                third  = IDX_B;
            end
            default: begin
                first  = IDX_A;
                second = IDX_B;
                third  = IDX_C;
            end
        endcase
        if (elig[first]) begin
            res = {1'b1, first};
        end else if (elig[second]) begin
            res = {1'b1, second};
        end else if (elig[third]) begin
            res = {1'b1, third};
        end else begin
            res = {1'b0, IDX_A};
        end
        return res;
    endfunction
`else
    // Fixed-priority pick A > B > C.  Returns {valid, index}.
    function automatic logic [2:0] pick_fixed(input logic [2:0] elig);
        logic [2:0] res;
        if (elig[0]) begin
            res = {1'b1, IDX_A};
        end else if (elig[1]) begin
            res = {1'b1, IDX_B};
        end else if (elig[2]) begin
            res = {1'b1, IDX_C};
        end else begin
            res = {1'b0, IDX_A};
        end
        return res;
    endfunction
`endif

    logic [0:0]        state_q,  state_d;
    logic [3:0]        cnt_q,    cnt_d;
    logic [1:0]        sel_q,    sel_d;
    logic [2:0]        gnt_q,    gnt_d;
    logic [2:0]        ack_q,    ack_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic [1:0]        last_q,   last_d;

    logic [2:0] elig_s;
    logic       win_valid_s;
    logic [1:0] win_idx_s;
    logic       win_we_s;

    // Arbitration: mask the requester being acknowledged, then pick a winner.
    always_comb begin
        elig_s = {req_c, req_b, req_a} & ~ack_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        {win_valid_s, win_idx_s} = pick_rr(elig_s, last_q);
`else
        {win_valid_s, win_idx_s} = pick_fixed(elig_s);
`endif
        case (win_idx_s)
            IDX_A:   win_we_s = we_a;
            IDX_B:   win_we_s = we_b;
            IDX_C:   win_we_s = we_c;
            default: win_we_s = 1'b0;
        endcase
    end

    // Next-state logic for the IDLE/ACCESS sequencer and all registered outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        ack_d    = 3'b000;
        mem_en_d = mem_en_q;
        mem_we_d = mem_we_q;
        rdata_d  = rdata_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_d  = ST_ACCESS;
                    cnt_d    = CNT_LOAD;
                    sel_d    = win_idx_s;
                    gnt_d    = idx_to_onehot(win_idx_s);
                    mem_en_d = 1'b1;
                    mem_we_d = win_we_s;
                    last_d   = win_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    ack_d    = gnt_q;
                    gnt_d    = 3'b000;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = 4'd0;
                gnt_d    = 3'b000;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers; asynchronous reset abandons any access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            sel_q    <= IDX_A;
            gnt_q    <= 3'b000;
            ack_q    <= 3'b000;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            rdata_q  <= '0;
            last_q   <= IDX_C;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            rdata_q  <= rdata_d;
            last_q   <= last_d;
        end
    end

    assign gnt_a  = gnt_q[0];
    assign gnt_b  = gnt_q[1];
    assign gnt_c  = gnt_q[2];
    assign ack_a  = ack_q[0];
    assign ack_b  = ack_q[1];
    assign ack_c  = ack_q[2];
    assign sel    = sel_q;
    assign mem_en = mem_en_q;
    assign mem_we = mem_we_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT = 2).
// Priority expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;
    localparam int DATA_W  = 16;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst;
    logic req_a, req_b, req_c;
    logic we_a, we_b, we_c;
    logic gnt_a, gnt_b, gnt_c;
    logic ack_a, ack_b, ack_c;
    logic [1:0] sel;
    logic mem_en, mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rdata;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .we_a(we_a), .we_b(we_b), .we_c(we_c),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .gnt_c(gnt_c),
        .ack_a(ack_a), .ack_b(ack_b), .ack_c(ack_c),
        .sel(sel), .mem_en(mem_en), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [2:0] gnt_s = {gnt_c, gnt_b, gnt_a};
    wire [2:0] ack_s = {ack_c, ack_b, ack_a};

    // Packed view of all outputs: {gnt, ack, sel, en, we, rdata}.
    function automatic logic [25:0] outs();
        return {gnt_s, ack_s, sel, mem_en, mem_we, rdata};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic [2:0] r, input logic [2:0] w);
        {req_c, req_b, req_a} = r;
        {we_c, we_b, we_a} = w;
    endtask

    typedef struct packed {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [15:0] mrd;
        logic [25:0] exp;
    } vec_t;

    vec_t tbl [7];

    // Reference model: transaction level, integer owner / remaining cycles.
    int          m_owner;
    int          m_left;
    int          m_last;
    logic [2:0]  m_ack;
    logic [1:0]  m_sel;
    logic        m_we;
    logic [15:0] m_rdata;

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_last = 2; m_ack = 3'b000;
        m_sel = 2'd0; m_we = 1'b0; m_rdata = 16'h0000;
    endtask

    task automatic model_step(input logic [2:0] r, input logic [2:0] w, input logic [15:0] mrd);
        logic [2:0] new_ack;
        logic [2:0] elig;
        int winner;
        int idx;
        new_ack = 3'b000;
        if (m_owner >= 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                new_ack[m_owner] = 1'b1;
                if (!m_we) m_rdata = mrd;
                m_owner = -1;
                m_we = 1'b0;
            end
        end else begin
            elig = r & ~m_ack;
            winner = -1;
            for (int k = 0; k < 3; k++) begin
                idx = RR ? (m_last + 1 + k) % 3 : k;
                if (winner < 0 && elig[idx]) winner = idx;
            end
            if (winner >= 0) begin
                m_owner = winner;
                m_left = MEM_LAT;
                m_sel = 2'(winner);
                m_we = w[winner];
                m_last = winner;
            end
        end
        m_ack = new_ack;
    endtask

    function automatic logic [25:0] model_outs();
        logic [2:0] g;
        g = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        return {g, m_ack, m_sel, (m_owner >= 0), m_we, m_rdata};
    endfunction

    initial begin
        int order [$];
        int last_ack_cyc;
        int n_ack;
        bit idle_seen;
        logic [2:0] prev_gnt;
        logic [2:0] r;
        logic [2:0] w;

        set_req(3'b000, 3'b000);
        mem_rdata = 16'h0000;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(outs()), 32'h0);
        rst = 1'b1;

        // ---- table: single read on A, then single write on C ----
        tbl[0] = '{3'b001, 3'b000, 16'h0000, {3'b001, 3'b000, 2'd0, 1'b1, 1'b0, 16'h0000}};
        tbl[1] = '{3'b001, 3'b000, 16'hBEEF, {3'b001, 3'b000, 2'd0, 1'b1, 1'b0, 16'h0000}};
        tbl[2] = '{3'b001, 3'b000, 16'hBEEF, {3'b000, 3'b001, 2'd0, 1'b0, 1'b0, 16'hBEEF}};
        tbl[3] = '{3'b100, 3'b100, 16'h1234, {3'b100, 3'b000, 2'd2, 1'b1, 1'b1, 16'hBEEF}};
        tbl[4] = '{3'b100, 3'b100, 16'h1234, {3'b100, 3'b000, 2'd2, 1'b1, 1'b1, 16'hBEEF}};
        tbl[5] = '{3'b100, 3'b100, 16'h1234, {3'b000, 3'b100, 2'd2, 1'b0, 1'b0, 16'hBEEF}};
        tbl[6] = '{3'b000, 3'b000, 16'h5555, {3'b000, 3'b000, 2'd2, 1'b0, 1'b0, 16'hBEEF}};
        for (int i = 0; i < 7; i++) begin
            set_req(tbl[i].req, tbl[i].we);
            mem_rdata = tbl[i].mrd;
            @(posedge clk);
            #1;
            check($sformatf("tbl_%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // ---- contention: all three requesting reads, held ----
        set_req(3'b111, 3'b000);
        prev_gnt = 3'b000;
        last_ack_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("sel_not_3", 32'(sel == 2'd3), 32'h0);
            if (gnt_s != 3'b000 && prev_gnt == 3'b000) begin
                order.push_back(gnt_a ? 0 : (gnt_b ? 1 : 2));
            end
            if (ack_s != 3'b000) begin
                check("ack_onehot", 32'($countones(ack_s)), 32'h1);
                if (last_ack_cyc >= 0) check("ack_spacing", 32'(c - last_ack_cyc), 32'(MEM_LAT + 1));
                last_ack_cyc = c;
            end
            prev_gnt = gnt_s;
        end
        check("grant_count", 32'(order.size() >= 6), 32'h1);
        for (int k = 0; k < 6 && k < order.size(); k++) begin
            check($sformatf("grant_order_%0d", k), 32'(order[k]), 32'(RR ? (k % 3) : (k % 2)));
        end
        set_req(3'b000, 3'b000);
        idle_seen = 1'b0;
        for (int c = 0; c < 10 && !idle_seen; c++) begin
            @(posedge clk);
            #1;
            if (gnt_s == 3'b000 && ack_s == 3'b000) idle_seen = 1'b1;
        end
        check("contention_idle", 32'(idle_seen), 32'h1);

        // ---- req dropped mid-access still completes ----
        set_req(3'b010, 3'b000);
        @(posedge clk);
        #1;
        check("drop_gnt", 32'(gnt_s), 32'h2);
        set_req(3'b000, 3'b000);
        n_ack = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (ack_b) n_ack++;
        end
        check("drop_ack_once", 32'(n_ack), 32'h1);

        // ---- reset in second ACCESS cycle of a B write ----
        set_req(3'b010, 3'b010);
        @(posedge clk);
        #1;
        check("rst_pre_gnt", 32'({gnt_s, mem_we, sel}), 32'({3'b010, 1'b1, 2'd1}));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", 32'(outs()), 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_no_ack", 32'(outs()), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_restart", 32'({gnt_s, ack_s, sel, mem_en, mem_we}),
              32'({3'b010, 3'b000, 2'd1, 1'b1, 1'b1}));
        n_ack = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (ack_b) begin
                n_ack++;
                set_req(3'b000, 3'b000);
            end
        end
        check("rst_restart_ack", 32'(n_ack), 32'h1);

        // ---- randomized run against the reference model ----
        set_req(3'b000, 3'b000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        r = 3'b000;
        w = 3'b000;
        for (int c = 0; c < 400; c++) begin
            mem_rdata = 16'($urandom);
            set_req(r, w);
            model_step(r, w, mem_rdata);
            @(posedge clk);
            #1;
            check("random", 32'(outs()), 32'(model_outs()));
            for (int i = 0; i < 3; i++) begin
                if (m_ack[i]) begin
                    r[i] = ($urandom_range(1, 0) == 1);
                    w[i] = ($urandom_range(1, 0) == 1);
                end else if (!r[i] && $urandom_range(9, 0) < 3) begin
                    r[i] = 1'b1;
                    w[i] = ($urandom_range(1, 0) == 1);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
